controlador_de_carga: RTL and testbench
=======================================

# controlador_de_carga

Boot-time loader and address arbiter for the instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially from address 0 through the memory's write port. While loading, it owns the memory address bus. After the last word is written, it hands the address bus to the CPU's PC and releases the CPU.

## Interface
Parameters:
- ADDR_WIDTH, 26, width of PC and memory address
- MEM_SIZE, 30, instruction memory depth in words; largest legal program length

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  one-cycle start request; begins a new load
- byte_dado  in  8  incoming program byte
- byte_valido  in  1  byte_dado is valid
- byte_pronto  out  1  loader can accept a byte this cycle
- pc  in  ADDR_WIDTH  CPU fetch address
- mem_endereco  out  ADDR_WIDTH  address to instruction memory
- mem_escrita  out  1  write strobe to instruction memory
- mem_dado  out  32  write data to instruction memory
- cpu_habilitar  out  1  CPU may run (PC advance enabled)
- carga_concluida  out  1  program fully loaded
- erro  out  1  header rejected

## Operation
- A byte is accepted on a rising edge where byte_valido && byte_pronto are both 1. The producer must hold byte_dado stable while byte_valido=1 && byte_pronto=0.
- Stream format: a 2-byte header N (16-bit word count, MSB first), followed by 4·N bytes. Each word is sent MSB first; the first byte fills bits [31:24].
- States and outputs:
  - OCIOSO: byte_pronto=0. iniciar → CABECALHO.
  - CABECALHO: byte_pronto=1. Accepts 2 bytes into N. On the 2nd accepted byte:
    - N > MEM_SIZE → ERRO
    - N == 0 → CONCLUIDO
    - otherwise → PALAVRA, with word index = 0 and byte count = 0
  - PALAVRA: byte_pronto=1. Shifts each accepted byte into the word register. On the 4th byte → ESCREVE.
  - ESCREVE: byte_pronto=0. mem_escrita=1, mem_endereco = word index (zero-extended), mem_dado = assembled word. Next edge: increment index. If the new index == N → CONCLUIDO, else → PALAVRA.
  - CONCLUIDO: cpu_habilitar=1, carga_concluida=1. iniciar → CABECALHO.
  - ERRO: erro=1. iniciar → CABECALHO.
- iniciar is ignored in CABECALHO, PALAVRA and ESCREVE. Entering CABECALHO clears N, the index, the byte count and the word register.
- Address mux: mem_endereco = pc (combinational pass-through) in OCIOSO, CONCLUIDO and ERRO. In all other states it is the zero-extended word index.
- mem_dado is 0 whenever mem_escrita=0.
- Width rules: N is 16 bits, compared unsigned against MEM_SIZE. The index is ADDR_WIDTH bits and never exceeds N.

## Timing
- Reset (asynchronous, while reset=0): state=OCIOSO. byte_pronto, mem_escrita, cpu_habilitar, carga_concluida and erro are all 0. mem_dado=0. mem_endereco=pc. All counters and registers are 0.
- Reset asserted mid-load aborts immediately. Any write strobe in flight drops in the same cycle. The memory keeps its partially written contents.
- Outputs are Moore-decoded from registered state. Only mem_endereco depends combinationally on pc.
- With byte_valido held at 1, each word takes 5 cycles: 4 accept cycles plus 1 ESCREVE cycle.
- Header-to-done latency for N=0 is 2 cycles.
- cpu_habilitar rises on the edge that ends the final ESCREVE cycle, i.e. one cycle after the last write strobe.
- byte_valido may drop at any point. State and partial word are held indefinitely; there is no timeout.
- Exactly one mem_escrita pulse occurs per word, at strictly increasing addresses 0..N-1.

## Test plan
- Reset: hold reset=0 with pc=5. Expect all outputs 0, mem_endereco=5, byte_pronto=0. Pulse iniciar while reset=0 → no change.
- Normal load: iniciar, then stream 00 02 78 00 00 0F FC 00 00 00 with byte_valido held at 1.
  - Expect writes (addr 0, 0x7800000F) and (addr 1, 0xFC000000), 5 cycles apart.
  - Expect cpu_habilitar=1 one cycle after the 2nd write, and mem_endereco then tracking pc.
- Backpressure and gaps: same stream with byte_valido toggled randomly. Expect identical writes and no duplicated or dropped bytes. Bytes presented during ESCREVE must wait (byte_pronto=0).
- N=0: header 00 00 → carga_concluida=1 two cycles after iniciar, no mem_escrita. A second iniciar returns to CABECALHO.
- Oversize: header 00 1F (31 > MEM_SIZE=30) → erro=1, no writes, cpu_habilitar=0. A following iniciar plus a valid 1-word stream → normal completion with erro=0.
- Reset mid-word: assert reset after 2 bytes of word 1.
  - Expect mem_escrita=0 and state OCIOSO asynchronously.
  - Restart the load; the first write must go to address 0.
  - iniciar pulsed during PALAVRA must have no effect.

Source files
------------

// File: rtl/controlador_de_carga.sv
// controlador_de_carga
//   Boot-time loader and address arbiter for the instruction memory.
//   Receives a program as a byte stream: a 16-bit word count N (MSB first)
//   followed by 4*N bytes. It assembles big-endian 32-bit words and writes
//   them to consecutive addresses starting at 0. While loading, it drives
//   the memory address bus. When loading ends, the bus follows the CPU PC
//   and the CPU is released.
//
// Ports
//   clock            system clock, rising edge
//   reset            asynchronous, active-low reset
//   iniciar          one-cycle start request
//   byte_dado        incoming program byte
//   byte_valido      byte_dado is valid
//   byte_pronto      loader accepts a byte this cycle
//   pc               CPU fetch address
//   mem_endereco     instruction memory address (pc or write index)
//   mem_escrita      instruction memory write strobe
//   mem_dado         instruction memory write data (0 when not writing)
//   cpu_habilitar    CPU may run
//   carga_concluida  program fully loaded
//   erro             header rejected (N > MEM_SIZE)
module controlador_de_carga #(
    parameter int ADDR_WIDTH = 26,
    parameter int MEM_SIZE   = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [7:0]            byte_dado,
    input  logic                  byte_valido,
    output logic                  byte_pronto,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] mem_endereco,
    output logic                  mem_escrita,
    output logic [31:0]           mem_dado,
    output logic                  cpu_habilitar,
    output logic                  carga_concluida,
    output logic                  erro
);

    typedef enum logic [2:0] {
        OCIOSO,
        CABECALHO,
        PALAVRA,
        ESCREVE,
        CONCLUIDO,
        ERRO
    } estado_t;

    estado_t               estado;
    logic [15:0]           n_palavras;
    logic [ADDR_WIDTH-1:0] indice;
    logic [1:0]            contador;
    logic [31:0]           palavra;
    logic                  usa_pc;

    logic                  aceita;
    logic [15:0]           n_novo;
    logic [31:0]           palavra_nova;
    logic [ADDR_WIDTH-1:0] indice_novo;

    assign aceita       = byte_valido && byte_pronto;
    assign n_novo       = {n_palavras[7:0], byte_dado};
    assign palavra_nova = {palavra[23:0], byte_dado};
    assign indice_novo  = indice + ADDR_WIDTH'(1);

    // The only combinational path to an output: PC pass-through when idle,
    // done or in error; otherwise the write index.
    assign mem_endereco = usa_pc ? pc : indice;

    // Outputs are registered alongside the state: each transition sets the
    // outputs that belong to the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= OCIOSO;
            n_palavras      <= '0;
            indice          <= '0;
            contador        <= '0;
            palavra         <= '0;
            usa_pc          <= 1'b1;
            byte_pronto     <= 1'b0;
            mem_escrita     <= 1'b0;
            mem_dado        <= '0;
            cpu_habilitar   <= 1'b0;
            carga_concluida <= 1'b0;
            erro            <= 1'b0;
        end else begin
            // ESCREVE lasts exactly one cycle, so the strobe and data
            // default low and are raised only on entry to ESCREVE.
            mem_escrita <= 1'b0;
            mem_dado    <= '0;

            case (estado)
                OCIOSO, CONCLUIDO, ERRO: begin
                    if (iniciar) begin
                        estado          <= CABECALHO;
                        n_palavras      <= '0;
                        indice          <= '0;
                        contador        <= '0;
                        palavra         <= '0;
                        usa_pc          <= 1'b0;
                        byte_pronto     <= 1'b1;
                        cpu_habilitar   <= 1'b0;
                        carga_concluida <= 1'b0;
                        erro            <= 1'b0;
                    end
                end

                CABECALHO: begin
                    if (aceita) begin
                        n_palavras <= n_novo;
                        contador   <= contador + 2'd1;
                        if (contador == 2'd1) begin
                            contador <= '0;
                            if (n_novo > 16'(MEM_SIZE)) begin
                                estado      <= ERRO;
                                byte_pronto <= 1'b0;
                                usa_pc      <= 1'b1;
                                erro        <= 1'b1;
                            end else if (n_novo == '0) begin
                                estado          <= CONCLUIDO;
                                byte_pronto     <= 1'b0;
                                usa_pc          <= 1'b1;
                                cpu_habilitar   <= 1'b1;
                                carga_concluida <= 1'b1;
                            end else begin
                                estado <= PALAVRA;
                                indice <= '0;
                            end
                        end
                    end
                end

                PALAVRA: begin
                    if (aceita) begin
                        palavra  <= palavra_nova;
                        contador <= contador + 2'd1;
                        if (contador == 2'd3) begin
                            estado      <= ESCREVE;
                            byte_pronto <= 1'b0;
                            mem_escrita <= 1'b1;
                            mem_dado    <= palavra_nova;
                        end
                    end
                end

                ESCREVE: begin
                    indice <= indice_novo;
                    if (indice_novo == ADDR_WIDTH'(n_palavras)) begin
                        estado          <= CONCLUIDO;
                        usa_pc          <= 1'b1;
                        cpu_habilitar   <= 1'b1;
                        carga_concluida <= 1'b1;
                    end else begin
                        estado      <= PALAVRA;
                        byte_pronto <= 1'b1;
                    end
                end

                default: begin
                    estado      <= OCIOSO;
                    usa_pc      <= 1'b1;
                    byte_pronto <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_de_carga.sv
// Directed testbench for controlador_de_carga.
module tb_controlador_de_carga;

    localparam int AW = 26;

    typedef logic [7:0] byte_t;

    logic          clock       = 1'b0;
    logic          reset       = 1'b0;
    logic          iniciar     = 1'b0;
    logic [7:0]    byte_dado   = '0;
    logic          byte_valido = 1'b0;
    logic [AW-1:0] pc          = '0;
    logic          byte_pronto;
    logic [AW-1:0] mem_endereco;
    logic          mem_escrita;
    logic [31:0]   mem_dado;
    logic          cpu_habilitar;
    logic          carga_concluida;
    logic          erro;

    int checks = 0;
    int errors = 0;

    controlador_de_carga #(
        .ADDR_WIDTH (AW),
        .MEM_SIZE   (30)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .byte_dado       (byte_dado),
        .byte_valido     (byte_valido),
        .byte_pronto     (byte_pronto),
        .pc              (pc),
        .mem_endereco    (mem_endereco),
        .mem_escrita     (mem_escrita),
        .mem_dado        (mem_dado),
        .cpu_habilitar   (cpu_habilitar),
        .carga_concluida (carga_concluida),
        .erro            (erro)
    );

    always #5 clock = ~clock;

    // Write log and handshake counters.
    int unsigned   ciclo      = 0;
    int unsigned   aceitos    = 0;
    int unsigned   colisoes   = 0;
    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    int unsigned   wr_ciclo[$];

    always @(posedge clock) begin
        ciclo <= ciclo + 1;
        if (byte_valido && byte_pronto) aceitos <= aceitos + 1;
        if (mem_escrita && byte_pronto) colisoes <= colisoes + 1;
        if (mem_escrita) begin
            wr_addr.push_back(mem_endereco);
            wr_data.push_back(mem_dado);
            wr_ciclo.push_back(ciclo);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    // Presents one byte and returns at the negedge after it was accepted.
    task automatic enviar(input byte_t b, input bit gaps);
        int unsigned espera;
        espera    = 0;
        byte_dado = b;
        forever begin
            if (gaps && $urandom_range(0, 2) == 0) byte_valido = 1'b0;
            else                                   byte_valido = 1'b1;
            if (byte_valido && byte_pronto) begin
                step();
                break;
            end
            step();
            espera++;
            if (espera > 100) begin
                checks++;
                errors++;
                $display("FAIL handshake_timeout: observed byte_pronto stuck at %0d, expected acceptance", byte_pronto);
                break;
            end
        end
    endtask

    task automatic enviar_lista(input byte_t bs[$], input bit gaps);
        foreach (bs[i]) enviar(bs[i], gaps);
        byte_valido = 1'b0;
    endtask

    byte_t       lista[$];
    int unsigned w0;
    int unsigned a0;
    int unsigned c0;

    initial begin
        // Reset held with pc=5 and iniciar pulsed.
        pc      = AW'(5);
        iniciar = 1'b1;
        step();
        step();
        check("rst_pronto", byte_pronto, 0);
        check("rst_escrita", mem_escrita, 0);
        check("rst_dado", mem_dado, 0);
        check("rst_cpu", cpu_habilitar, 0);
        check("rst_concl", carga_concluida, 0);
        check("rst_erro", erro, 0);
        check("rst_end", mem_endereco, 5);
        iniciar = 1'b0;
        reset   = 1'b1;
        step();
        check("pos_rst_pronto", byte_pronto, 0);
        check("pos_rst_end", mem_endereco, 5);

        // Normal load, byte_valido held high.
        pc = AW'('h123);
        pulso_iniciar();
        check("cab_pronto", byte_pronto, 1);
        check("cab_end", mem_endereco, 0);
        check("cab_cpu", cpu_habilitar, 0);
        w0 = wr_addr.size();
        a0 = aceitos;
        c0 = colisoes;
        lista = '{8'h00, 8'h02, 8'h78, 8'h00, 8'h00, 8'h0F, 8'hFC, 8'h00, 8'h00, 8'h00};
        enviar_lista(lista, 1'b0);
        check("w2_escrita", mem_escrita, 1);
        check("w2_end", mem_endereco, 1);
        check("w2_dado", mem_dado, 32'hFC000000);
        check("w2_cpu", cpu_habilitar, 0);
        check("w2_pronto", byte_pronto, 0);
        step();
        check("fim_cpu", cpu_habilitar, 1);
        check("fim_concl", carga_concluida, 1);
        check("fim_escrita", mem_escrita, 0);
        check("fim_dado", mem_dado, 0);
        check("fim_end", mem_endereco, 32'h123);
        pc = AW'('h2AB);
        #1;
        check("fim_end_pc", mem_endereco, 32'h2AB);
        check("n_escritas", wr_addr.size() - w0, 2);
        check("wr0_end", wr_addr[w0], 0);
        check("wr0_dado", wr_data[w0], 32'h7800000F);
        check("wr1_end", wr_addr[w0+1], 1);
        check("wr1_dado", wr_data[w0+1], 32'hFC000000);
        check("wr_intervalo", wr_ciclo[w0+1] - wr_ciclo[w0], 5);
        check("aceitos", aceitos - a0, 10);
        check("colisoes", colisoes - c0, 0);

        // Same stream with random gaps in byte_valido.
        step();
        pulso_iniciar();
        w0 = wr_addr.size();
        a0 = aceitos;
        c0 = colisoes;
        enviar_lista(lista, 1'b1);
        step();
        check("gap_concl", carga_concluida, 1);
        check("gap_n_escritas", wr_addr.size() - w0, 2);
        check("gap_wr0_end", wr_addr[w0], 0);
        check("gap_wr0_dado", wr_data[w0], 32'h7800000F);
        check("gap_wr1_end", wr_addr[w0+1], 1);
        check("gap_wr1_dado", wr_data[w0+1], 32'hFC000000);
        check("gap_aceitos", aceitos - a0, 10);
        check("gap_colisoes", colisoes - c0, 0);

        // N=0: done two cycles after iniciar is sampled.
        w0          = wr_addr.size();
        byte_dado   = 8'h00;
        byte_valido = 1'b1;
        iniciar     = 1'b1;
        step();
        iniciar = 1'b0;
        check("n0_cab", carga_concluida, 0);
        step();
        check("n0_meio", carga_concluida, 0);
        step();
        byte_valido = 1'b0;
        check("n0_concl", carga_concluida, 1);
        check("n0_cpu", cpu_habilitar, 1);
        check("n0_escritas", wr_addr.size() - w0, 0);
        pulso_iniciar();
        check("n0_reinicio_pronto", byte_pronto, 1);
        check("n0_reinicio_concl", carga_concluida, 0);

        // Oversize header 31 > 30.
        lista = '{8'h00, 8'h1F};
        enviar_lista(lista, 1'b0);
        check("big_erro", erro, 1);
        check("big_cpu", cpu_habilitar, 0);
        check("big_concl", carga_concluida, 0);
        check("big_pronto", byte_pronto, 0);
        check("big_end", mem_endereco, 32'h2AB);
        check("big_escritas", wr_addr.size() - w0, 0);
        pulso_iniciar();
        check("big_reinicio_erro", erro, 0);
        lista = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        enviar_lista(lista, 1'b0);
        step();
        check("big_ok_concl", carga_concluida, 1);
        check("big_ok_erro", erro, 0);
        check("big_ok_escritas", wr_addr.size() - w0, 1);
        check("big_ok_end", wr_addr[w0], 0);
        check("big_ok_dado", wr_data[w0], 32'hDEADBEEF);

        // N=30 is legal; iniciar during PALAVRA is ignored.
        pulso_iniciar();
        lista = '{8'h00, 8'h1E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        enviar_lista(lista, 1'b0);
        check("n30_erro", erro, 0);
        check("n30_pronto", byte_pronto, 1);
        check("n30_end", mem_endereco, 1);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        step();
        check("ign_end", mem_endereco, 1);
        check("ign_pronto", byte_pronto, 1);
        lista = '{8'h77, 8'h88};
        enviar_lista(lista, 1'b0);
        check("ign_escrita", mem_escrita, 1);
        check("ign_dado", mem_dado, 32'h55667788);
        step();
        lista = '{8'h99, 8'hAA};
        enviar_lista(lista, 1'b0);

        // Reset mid-word acts without waiting for a clock edge.
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pronto", byte_pronto, 0);
        check("mid_rst_escrita", mem_escrita, 0);
        check("mid_rst_end", mem_endereco, 32'h2AB);
        step();
        reset = 1'b1;

        // Reset during the write cycle drops the strobe at once.
        pulso_iniciar();
        lista = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        enviar_lista(lista, 1'b0);
        check("rst_wr_escrita_antes", mem_escrita, 1);
        check("rst_wr_end_antes", mem_endereco, 0);
        #2 reset = 1'b0;
        #1;
        check("rst_wr_escrita", mem_escrita, 0);
        check("rst_wr_dado", mem_dado, 0);
        check("rst_wr_end", mem_endereco, 32'h2AB);
        step();
        reset = 1'b1;

        // Restart after reset: first write lands at address 0.
        w0 = wr_addr.size();
        pulso_iniciar();
        lista = '{8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        enviar_lista(lista, 1'b0);
        step();
        check("rec_concl", carga_concluida, 1);
        check("rec_escritas", wr_addr.size() - w0, 1);
        check("rec_end", wr_addr[w0], 0);
        check("rec_dado", wr_data[w0], 32'hA1B2C3D4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
